// File: rtl/id_ctrl_stage_pkg.sv
// Shared encodings, control-word layout and counter width for the ID control stage.
// Used by id_ctrl_decode and id_ctrl_stage (optional feature macro: DECODE_RI_EXC_EN).
package id_ctrl_stage_pkg;

    localparam int unsigned CNT_W = 6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNC_SLL   = 6'h00;
    localparam logic [5:0] FUNC_SRL   = 6'h02;
    localparam logic [5:0] FUNC_SRA   = 6'h03;
    localparam logic [5:0] FUNC_SLLV  = 6'h04;
    localparam logic [5:0] FUNC_SRLV  = 6'h06;
    localparam logic [5:0] FUNC_SRAV  = 6'h07;
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;
    localparam logic [5:0] FUNC_ADD   = 6'h20;
    localparam logic [5:0] FUNC_ADDU  = 6'h21;
    localparam logic [5:0] FUNC_SUB   = 6'h22;
    localparam logic [5:0] FUNC_SUBU  = 6'h23;
    localparam logic [5:0] FUNC_AND   = 6'h24;
    localparam logic [5:0] FUNC_OR    = 6'h25;
    localparam logic [5:0] FUNC_XOR   = 6'h26;
    localparam logic [5:0] FUNC_NOR   = 6'h27;
    localparam logic [5:0] FUNC_SLT   = 6'h2A;
    localparam logic [5:0] FUNC_SLTU  = 6'h2B;

    localparam int unsigned CTRL_REGWRITE   = 11;
    localparam int unsigned CTRL_REGDST     = 10;
    localparam int unsigned CTRL_ALUSRC     = 9;
    localparam int unsigned CTRL_BRANCH     = 8;
    localparam int unsigned CTRL_MEMWRITE   = 7;
    localparam int unsigned CTRL_MEMTOREG   = 6;
    localparam int unsigned CTRL_JUMP       = 5;
    localparam int unsigned CTRL_HILO_WRITE = 4;
    localparam int unsigned CTRL_IS_IMM     = 3;
    localparam int unsigned CTRL_MD_START   = 2;
    localparam int unsigned CTRL_MD_DIV     = 1;
    localparam int unsigned CTRL_MD_SIGNED  = 0;

    typedef logic [11:0] ctrl_word_t;

endpackage

// File: rtl/id_ctrl_decode.sv
// Combinational main decoder: instruction word to control word, reserved flag and
// HI/LO-class flag.
module id_ctrl_decode
    import id_ctrl_stage_pkg::*;
(
    input  logic [31:0] instr_i,
    output ctrl_word_t  ctrl_o,
    output logic        ri_o,
    output logic        hilo_o
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_fields;

    assign op            = instr_i[31:26];
    assign funct         = instr_i[5:0];
    assign unused_fields = ^instr_i[25:6];

    always_comb begin
        ctrl_o = '0;
        ri_o   = 1'b0;
        hilo_o = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNC_ADD, FUNC_ADDU, FUNC_SUB, FUNC_SUBU, FUNC_SLT, FUNC_SLTU,
                    FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR, FUNC_SLL, FUNC_SLLV,
                    FUNC_SRL, FUNC_SRLV, FUNC_SRA, FUNC_SRAV: begin
                        ctrl_o[CTRL_REGWRITE] = 1'b1;
                        ctrl_o[CTRL_REGDST]   = 1'b1;
                    end
                    FUNC_MFHI, FUNC_MFLO: begin
                        ctrl_o[CTRL_REGWRITE] = 1'b1;
                        ctrl_o[CTRL_REGDST]   = 1'b1;
                        hilo_o                = 1'b1;
                    end
                    FUNC_MTHI, FUNC_MTLO: begin
                        ctrl_o[CTRL_REGWRITE]   = 1'b1;
                        ctrl_o[CTRL_REGDST]     = 1'b1;
                        ctrl_o[CTRL_HILO_WRITE] = 1'b1;
                        hilo_o                  = 1'b1;
                    end
                    FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
                        // funct[1] separates DIV from MULT, funct[0] marks the unsigned form
                        ctrl_o[CTRL_HILO_WRITE] = 1'b1;
                        ctrl_o[CTRL_MD_START]   = 1'b1;
                        ctrl_o[CTRL_MD_DIV]     = funct[1];
                        ctrl_o[CTRL_MD_SIGNED]  = ~funct[0];
                        hilo_o                  = 1'b1;
                    end
                    default: ri_o = 1'b1;
                endcase
            end
            OP_ADDI: begin
                ctrl_o[CTRL_REGWRITE] = 1'b1;
                ctrl_o[CTRL_ALUSRC]   = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_o[CTRL_REGWRITE] = 1'b1;
                ctrl_o[CTRL_ALUSRC]   = 1'b1;
                ctrl_o[CTRL_IS_IMM]   = 1'b1;
            end
            OP_LW: begin
                ctrl_o[CTRL_REGWRITE] = 1'b1;
                ctrl_o[CTRL_ALUSRC]   = 1'b1;
                ctrl_o[CTRL_MEMTOREG] = 1'b1;
            end
            OP_SW: begin
                ctrl_o[CTRL_ALUSRC]   = 1'b1;
                ctrl_o[CTRL_MEMWRITE] = 1'b1;
            end
            OP_BEQ:  ctrl_o[CTRL_BRANCH] = 1'b1;
            OP_J:    ctrl_o[CTRL_JUMP]   = 1'b1;
            default: ri_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// Registered ID/EX control stage with valid/ready handshake and HI/LO scoreboard.
// DECODE_RI_EXC_EN: when defined, reserved instructions raise out_ri alongside the word.
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 34,
    parameter int unsigned PC_W       = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc,
    output logic [11:0]     out_ctrl,
    output logic            out_ri,
    output logic            md_busy
);

    ctrl_word_t dec_ctrl;
    logic       dec_ri;
    logic       dec_hilo;

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [PC_W-1:0] pc_q, pc_d;
    ctrl_word_t      ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hazard;
    logic ready;
    logic accept;
    logic issue;

    id_ctrl_decode u_decode (
        .instr_i (in_instr),
        .ctrl_o  (dec_ctrl),
        .ri_o    (dec_ri),
        .hilo_o  (dec_hilo)
    );

    always_comb begin
        // A held muldiv that has not issued yet counts as in flight
        hazard = dec_hilo && ((cnt_q != '0) || (valid_q && ctrl_q[CTRL_MD_START]));
        ready  = !flush && !hazard && (!valid_q || out_ready);
        accept = in_valid && ready;
        issue  = valid_q && out_ready && ctrl_q[CTRL_MD_START];
    end

    always_comb begin
        cnt_d = cnt_q;
        if (issue) begin
            cnt_d = ctrl_q[CTRL_MD_DIV] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        ctrl_d  = ctrl_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
            instr_d = in_instr;
            pc_d    = in_pc;
            ctrl_d  = dec_ctrl;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DECODE_RI_EXC_EN
    logic ri_q, ri_d;

    always_comb begin
        ri_d = accept ? dec_ri : ri_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ri_q <= 1'b0;
        end else begin
            ri_q <= ri_d;
        end
    end

    assign out_ri = ri_q;
`else
    logic unused_ri;

    assign unused_ri = dec_ri;
    assign out_ri    = 1'b0;
`endif

    assign in_ready  = ready;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = pc_q;
    assign out_ctrl  = ctrl_q;
    assign md_busy   = (cnt_q != '0);

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed scoreboard bench for id_ctrl_stage (MUL_CYCLES=4, DIV_CYCLES=34).
module tb_id_ctrl_stage;

`ifdef DECODE_RI_EXC_EN
    localparam bit RI_EN = 1'b1;
`else
    localparam bit RI_EN = 1'b0;
`endif

    localparam logic [31:0] I_LW    = 32'h8C22_0004;
    localparam logic [31:0] I_ADDI  = 32'h2021_0005;
    localparam logic [31:0] I_SW    = 32'hAC22_0008;
    localparam logic [31:0] I_BEQ   = 32'h1022_0003;
    localparam logic [31:0] I_J     = 32'h0800_0010;
    localparam logic [31:0] I_ADDU  = 32'h0022_1821;
    localparam logic [31:0] I_DIV   = 32'h0022_001A;
    localparam logic [31:0] I_DIVU  = 32'h0022_001B;
    localparam logic [31:0] I_MULT  = 32'h0022_0018;
    localparam logic [31:0] I_MULTU = 32'h0022_0019;
    localparam logic [31:0] I_MFHI  = 32'h0000_1810;
    localparam logic [31:0] I_MFLO  = 32'h0000_1812;
    localparam logic [31:0] I_MTHI  = 32'h0020_0011;
    localparam logic [31:0] I_SLL   = 32'h0002_1080;
    localparam logic [31:0] I_SLT   = 32'h0022_182A;
    localparam logic [31:0] I_ANDI  = 32'h3022_FFFF;
    localparam logic [31:0] I_LUI   = 32'h3C01_1234;
    localparam logic [31:0] I_RSVOP = 32'hFC00_0000;
    localparam logic [31:0] I_RSVFN = 32'h0000_0001;

    typedef struct {
        logic [11:0] ctrl;
        logic        ri;
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [11:0] out_ctrl;
    logic        out_ri;
    logic        md_busy;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   busy_cycles = 0;
    int   pc_seq = 0;

    id_ctrl_stage #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (34),
        .PC_W       (32)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_ctrl  (out_ctrl),
        .out_ri    (out_ri),
        .md_busy   (md_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pre-edge sampling of the output side: scoreboard pop and busy-cycle count
    task automatic mon();
        exp_t e;
        if (md_busy) busy_cycles++;
        if (resetn && out_valid && (flush || out_ready)) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                if (!flush) begin
                    check("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                    check("out_ri", 64'(out_ri), 64'(e.ri));
                    check("out_instr", 64'(out_instr), 64'(e.instr));
                    check("out_pc", 64'(out_pc), 64'(e.pc));
                end
            end
        end
    endtask

    // Called between offsets +1..+2 after a negedge; returns at negedge+1
    task automatic tick();
        #1;
        mon();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [11:0] ctrl, input logic rsv,
                        input int budget, output int waited, output logic [31:0] pc);
        exp_t e;
        pc = 32'h0040_0000 + 32'(pc_seq) * 32'd4;
        pc_seq++;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        waited   = 0;
        #1;
        while (!in_ready && waited < budget) begin
            tick();
            waited++;
        end
        check("accept_in_budget", 64'(in_ready), 64'd1);
        if (in_ready) begin
            e.ctrl  = ctrl;
            e.ri    = rsv & RI_EN;
            e.instr = instr;
            e.pc    = pc;
            exp_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int          w;
        int          base;
        logic [31:0] pc;

        resetn    = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_LW;
        in_pc     = 32'h0000_1000;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset with a valid LW presented
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_out_ri", 64'(out_ri), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_md_busy", 64'(md_busy), 64'd0);
        tick();
        check("rst_hold_valid", 64'(out_valid), 64'd0);
        resetn = 1'b1;
        send(I_LW, 12'hA40, 1'b0, 4, w, pc);
        check("lw_latency_valid", 64'(out_valid), 64'd1);
        check("lw_ctrl", 64'(out_ctrl), 64'hA40);
        check("lw_pc", 64'(out_pc), 64'(pc));

        // Back-to-back stream
        send(I_ADDI, 12'hA00, 1'b0, 4, w, pc);
        check("addi_no_wait", 64'(w), 64'd0);
        send(I_SW, 12'h280, 1'b0, 4, w, pc);
        check("sw_no_wait", 64'(w), 64'd0);
        send(I_BEQ, 12'h100, 1'b0, 4, w, pc);
        check("beq_no_wait", 64'(w), 64'd0);
        send(I_J, 12'h020, 1'b0, 4, w, pc);
        check("j_no_wait", 64'(w), 64'd0);

        // Backpressure holds J for 3 cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = I_ADDU;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_instr", 64'(out_instr), 64'(I_J));
            check("bp_out_ctrl", 64'(out_ctrl), 64'h020);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // DIV countdown with independent ADDUs and a waiting MFHI
        send(I_DIV, 12'h017, 1'b0, 4, w, pc);
        base = busy_cycles;
        send(I_ADDU, 12'hC00, 1'b0, 4, w, pc);
        check("addu1_unstalled", 64'(w), 64'd0);
        send(I_ADDU, 12'hC00, 1'b0, 4, w, pc);
        check("addu2_unstalled", 64'(w), 64'd0);
        check("div_busy", 64'(md_busy), 64'd1);
        send(I_MFHI, 12'hC00, 1'b0, 60, w, pc);
        check("mfhi_wait", 64'(w), 64'd33);
        check("div_busy_cycles", 64'(busy_cycles - base), 64'd34);
        tick();

        // MULT held downstream blocks MFLO, then 4 cycles of countdown
        out_ready = 1'b0;
        send(I_MULT, 12'h015, 1'b0, 4, w, pc);
        in_valid = 1'b1;
        in_instr = I_MFLO;
        #1;
        check("mflo_stall_bp", 64'(in_ready), 64'd0);
        tick();
        out_ready = 1'b1;
        #1;
        check("mflo_stall_held_mult", 64'(in_ready), 64'd0);
        tick();
        send(I_MFLO, 12'hC00, 1'b0, 20, w, pc);
        check("mflo_wait", 64'(w), 64'd4);
        tick();

        // Flush a held MULTU before it issues
        out_ready = 1'b0;
        send(I_MULTU, 12'h014, 1'b0, 4, w, pc);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = I_ADDU;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        check("flush_kill_valid", 64'(out_valid), 64'd0);
        check("flush_no_count", 64'(md_busy), 64'd0);
        out_ready = 1'b1;
        #1;
        check("flush_blocks_idle", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush_never_issued", 64'(md_busy), 64'd0);

        // Flush during a DIVU countdown leaves the count running
        send(I_DIVU, 12'h016, 1'b0, 4, w, pc);
        base = busy_cycles;
        tick();
        flush = 1'b1;
        repeat (5) tick();
        check("divu_busy_in_flush", 64'(md_busy), 64'd1);
        flush = 1'b0;
        repeat (35) tick();
        check("divu_busy_cycles", 64'(busy_cycles - base), 64'd34);

        // Assorted decodes, including reserved encodings
        send(I_SLL, 12'hC00, 1'b0, 4, w, pc);
        send(I_ANDI, 12'hA08, 1'b0, 4, w, pc);
        send(I_LUI, 12'hA08, 1'b0, 4, w, pc);
        send(I_MTHI, 12'hC10, 1'b0, 4, w, pc);
        send(I_SLT, 12'hC00, 1'b0, 4, w, pc);
        send(I_RSVOP, 12'h000, 1'b1, 4, w, pc);
        check("rsvop_ri", 64'(out_ri), 64'(RI_EN));
        check("rsvop_ctrl", 64'(out_ctrl), 64'd0);
        send(I_RSVFN, 12'h000, 1'b1, 4, w, pc);
        check("rsvfn_no_wait", 64'(w), 64'd0);
        tick();

        // Asynchronous reset mid-countdown with a word held
        send(I_MULT, 12'h015, 1'b0, 4, w, pc);
        send(I_ADDU, 12'hC00, 1'b0, 4, w, pc);
        out_ready = 1'b0;
        check("pre_reset_busy", 64'(md_busy), 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_busy", 64'(md_busy), 64'd0);
        check("async_rst_ctrl", 64'(out_ctrl), 64'd0);
        check("async_rst_instr", 64'(out_instr), 64'd0);
        check("async_rst_pc", 64'(out_pc), 64'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;
        tick();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
